// File: rtl/fm_buf_sched.sv
// fm_buf_sched: decimating 64x10 capture buffer. Once a frame is frozen,
// two readers share the buffer through a round-robin arbiter.
// Optional READY-state watchdog: define FM_SCHED_TIMEOUT_EN.
module fm_buf_sched #(
    parameter int unsigned DECIM   = 50,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic       clk_32m,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] ad_data,
    input  logic       rd_req1,
    input  logic       rd_req2,
    input  logic [5:0] rd_addr1,
    input  logic [5:0] rd_addr2,
    input  logic       rd_done1,
    input  logic       rd_done2,
    output logic       rd_gnt1,
    output logic       rd_gnt2,
    output logic       rd_vld1,
    output logic       rd_vld2,
    output logic [9:0] rd_data1,
    output logic [9:0] rd_data2,
    output logic       buf_ready,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_READY   = 2'd2;
    localparam logic [7:0] DEC_LAST  = 8'(DECIM - 1);

    logic [1:0] r_state;
    logic [7:0] r_dec;
    logic [5:0] r_wr_ptr;
    logic [9:0] r_mem [0:63];
    logic       r_done1;
    logic       r_done2;
    logic       r_prio2;
    logic       r_vld1;
    logic       r_vld2;
    logic [9:0] r_data1;
    logic [9:0] r_data2;
    logic [7:0] r_frame_cnt;

    logic       w_in_ready;
    logic       w_sample;
    logic       w_gnt1;
    logic       w_gnt2;
    logic       w_done1_set;
    logic       w_done2_set;
    logic       w_release;
    logic       w_wd_expire;
    logic [5:0] w_mem_addr;
    logic [9:0] w_mem_rdata;

    assign w_in_ready  = (r_state == S_READY);
    assign w_sample    = (r_state == S_CAPTURE) && (r_dec == DEC_LAST);

    // Round robin: r_prio2 set means reader 2 wins a tie.
    assign w_gnt1      = w_in_ready & rd_req1 & (~rd_req2 | ~r_prio2);
    assign w_gnt2      = w_in_ready & rd_req2 & (~rd_req1 |  r_prio2);

    assign w_done1_set = r_done1 | (w_in_ready & rd_done1);
    assign w_done2_set = r_done2 | (w_in_ready & rd_done2);
    assign w_release   = w_in_ready & w_done1_set & w_done2_set;

    // Single buffer port: writes only in CAPTURE, reads only in READY.
    assign w_mem_addr  = w_sample ? r_wr_ptr : (w_gnt1 ? rd_addr1 : rd_addr2);
    assign w_mem_rdata = r_mem[w_mem_addr];

`ifdef FM_SCHED_TIMEOUT_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
    logic [31:0] r_wd_cnt;
    logic        r_timeout;

    assign w_wd_expire = w_in_ready && (r_wd_cnt == WD_LAST);
    assign timeout     = r_timeout;

    // Watchdog: counts READY cycles from zero, pulses timeout on expiry.
    always_ff @(posedge clk_32m) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wd_expire;
            r_wd_cnt  <= w_in_ready ? r_wd_cnt + 32'd1 : '0;
        end
    end
`else
    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Sample buffer: not reset so contents survive reset and frame release.
    always_ff @(posedge clk_32m) begin
        if (!rst && w_sample) begin
            r_mem[w_mem_addr] <= ad_data;
        end
    end

    // Read return path: one-cycle valid pulse, data held between reads.
    always_ff @(posedge clk_32m) begin
        if (rst) begin
            r_vld1  <= 1'b0;
            r_vld2  <= 1'b0;
            r_data1 <= '0;
            r_data2 <= '0;
        end else begin
            r_vld1 <= w_gnt1;
            r_vld2 <= w_gnt2;
            if (w_gnt1) r_data1 <= w_mem_rdata;
            if (w_gnt2) r_data2 <= w_mem_rdata;
        end
    end

    // Arbiter pointer: priority moves away from whoever was last granted.
    always_ff @(posedge clk_32m) begin
        if (rst) begin
            r_prio2 <= 1'b0;
        end else if (w_gnt1) begin
            r_prio2 <= 1'b1;
        end else if (w_gnt2) begin
            r_prio2 <= 1'b0;
        end
    end

    // Frame FSM: capture with decimation, then hold until both readers release.
    always_ff @(posedge clk_32m) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dec       <= '0;
            r_wr_ptr    <= '0;
            r_done1     <= 1'b0;
            r_done2     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_CAPTURE;
                        r_dec    <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_sample) begin
                        r_dec    <= '0;
                        r_wr_ptr <= r_wr_ptr + 6'd1;
                        if (r_wr_ptr == 6'd63) begin
                            r_state <= S_READY;
                            r_done1 <= 1'b0;
                            r_done2 <= 1'b0;
                        end
                    end else begin
                        r_dec <= r_dec + 8'd1;
                    end
                end
                S_READY: begin
                    if (w_release || w_wd_expire) begin
                        r_state     <= S_IDLE;
                        r_done1     <= 1'b0;
                        r_done2     <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    end else begin
                        r_done1 <= w_done1_set;
                        r_done2 <= w_done2_set;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_gnt1   = w_gnt1;
    assign rd_gnt2   = w_gnt2;
    assign rd_vld1   = r_vld1;
    assign rd_vld2   = r_vld2;
    assign rd_data1  = r_data1;
    assign rd_data2  = r_data2;
    assign busy      = (r_state == S_CAPTURE);
    assign buf_ready = w_in_ready;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fm_buf_sched.sv
// Directed bench for fm_buf_sched: DECIM=50 instance for capture, read and
// release behaviour; DECIM=1 instance for single-cycle decimation and
// frame counter wrap.
module tb_fm_buf_sched;

    logic clk_32m = 1'b0;
    always #5 clk_32m = ~clk_32m;

    int checks   = 0;
    int failures = 0;

    // DECIM=50 instance signals
    logic       rst, start, rd_req1, rd_req2, rd_done1, rd_done2;
    logic [9:0] ad_data;
    logic [5:0] rd_addr1, rd_addr2;
    logic       rd_gnt1, rd_gnt2, rd_vld1, rd_vld2, buf_ready, busy, timeout;
    logic [9:0] rd_data1, rd_data2;
    logic [7:0] frame_cnt;

    // DECIM=1 instance signals
    logic       rst_b, start_b, rd_req1_b, rd_req2_b, rd_done1_b, rd_done2_b;
    logic [9:0] ad_data_b;
    logic [5:0] rd_addr1_b, rd_addr2_b;
    logic       rd_gnt1_b, rd_gnt2_b, rd_vld1_b, rd_vld2_b, buf_ready_b, busy_b, timeout_b;
    logic [9:0] rd_data1_b, rd_data2_b;
    logic [7:0] frame_cnt_b;

    fm_buf_sched #(.DECIM(50), .TIMEOUT(100)) u_dut (
        .clk_32m(clk_32m), .rst(rst), .start(start), .ad_data(ad_data),
        .rd_req1(rd_req1), .rd_req2(rd_req2), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_done1(rd_done1), .rd_done2(rd_done2), .rd_gnt1(rd_gnt1), .rd_gnt2(rd_gnt2),
        .rd_vld1(rd_vld1), .rd_vld2(rd_vld2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .buf_ready(buf_ready), .busy(busy), .frame_cnt(frame_cnt), .timeout(timeout)
    );

    fm_buf_sched #(.DECIM(1), .TIMEOUT(100)) u_dut_d1 (
        .clk_32m(clk_32m), .rst(rst_b), .start(start_b), .ad_data(ad_data_b),
        .rd_req1(rd_req1_b), .rd_req2(rd_req2_b), .rd_addr1(rd_addr1_b), .rd_addr2(rd_addr2_b),
        .rd_done1(rd_done1_b), .rd_done2(rd_done2_b), .rd_gnt1(rd_gnt1_b), .rd_gnt2(rd_gnt2_b),
        .rd_vld1(rd_vld1_b), .rd_vld2(rd_vld2_b), .rd_data1(rd_data1_b), .rd_data2(rd_data2_b),
        .buf_ready(buf_ready_b), .busy(busy_b), .frame_cnt(frame_cnt_b), .timeout(timeout_b)
    );

    task automatic tick();
        @(posedge clk_32m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Ramp captured at DECIM=50 with offset: sample k is ramp value 50k+49+off.
    function automatic logic [9:0] ramp50(input int k, input int off);
        return 10'(50 * k + 49 + off);
    endfunction

    initial begin
        int bad;
        int gbad;
        int ready_ticks;
        int w;

        rst = 1'b1; start = 1'b0; ad_data = '0;
        rd_req1 = 1'b0; rd_req2 = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
        rd_done1 = 1'b0; rd_done2 = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; ad_data_b = '0;
        rd_req1_b = 1'b0; rd_req2_b = 1'b0; rd_addr1_b = '0; rd_addr2_b = '0;
        rd_done1_b = 1'b0; rd_done2_b = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", buf_ready, 0);
        chk("rst_vld", {rd_vld1, rd_vld2}, 0);
        chk("rst_data", {rd_data1, rd_data2}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        rst_b = 1'b0;

        // request in IDLE gets no grant
        rd_req1 = 1'b1; rd_addr1 = 6'd3;
        #1;
        chk("idle_no_gnt", {rd_gnt1, rd_gnt2}, 0);
        tick();
        chk("idle_no_vld", rd_vld1, 0);
        rd_req1 = 1'b0;

        // ---- capture 1: DECIM=50, ramp per cycle ----
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int n = 0; n < 3200; n++) begin
            ad_data = 10'(n);
            if (busy !== 1'b1 || buf_ready !== 1'b0) bad++;
            if (n == 500) begin
                rd_req1 = 1'b1; rd_addr1 = 6'd5;
                #1;
                chk("capture_no_gnt", {rd_gnt1, rd_gnt2}, 0);
            end
            if (n == 501) rd_req1 = 1'b0;
            start    = (n == 1000);
            rd_done2 = (n == 2000);
            tick();
        end
        start = 1'b0; rd_done2 = 1'b0;
        chk("busy_3200_cycles", bad, 0);
        chk("ready_at_3201", buf_ready, 1);
        chk("busy_off_ready", busy, 0);

        // start ignored in READY
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_ready", buf_ready, 1);

        // single read, reader 1, addr 5
        rd_req1 = 1'b1; rd_addr1 = 6'd5;
        #1;
        chk("gnt1_same_cycle", {rd_gnt1, rd_gnt2}, 2'b10);
        tick();
        chk("vld1_next_cycle", rd_vld1, 1);
        chk("data1_addr5", rd_data1, ramp50(5, 0));

        // back-to-back reads of the whole buffer
        bad = 0; gbad = 0;
        for (int k = 0; k < 64; k++) begin
            rd_addr1 = 6'(k);
            #1;
            if (rd_gnt1 !== 1'b1 || rd_gnt2 !== 1'b0) gbad++;
            tick();
            if (rd_vld1 !== 1'b1 || rd_data1 !== ramp50(k, 0)) bad++;
        end
        chk("b2b_grants", gbad, 0);
        chk("b2b_data", bad, 0);
        rd_req1 = 1'b0;
        tick();
        chk("vld1_drops", rd_vld1, 0);
        chk("data1_holds", rd_data1, ramp50(63, 0));

        // reader 2 alone, addr 7
        rd_req2 = 1'b1; rd_addr2 = 6'd7;
        #1;
        chk("gnt2_sole", {rd_gnt1, rd_gnt2}, 2'b01);
        tick();
        rd_req2 = 1'b0;
        chk("vld2_sole", {rd_vld1, rd_vld2}, 2'b01);
        chk("data2_addr7", rd_data2, ramp50(7, 0));

        // both held 4 cycles: reader 1 was not last granted, so 1,2,1,2
        rd_req1 = 1'b1; rd_addr1 = 6'd10;
        rd_req2 = 1'b1; rd_addr2 = 6'd20;
        bad = 0; gbad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if ({rd_gnt1, rd_gnt2} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) gbad++;
            tick();
            if (i % 2 == 0) begin
                if ({rd_vld1, rd_vld2} !== 2'b10 || rd_data1 !== ramp50(10, 0)) bad++;
            end else begin
                if ({rd_vld1, rd_vld2} !== 2'b01 || rd_data2 !== ramp50(20, 0)) bad++;
            end
        end
        rd_req1 = 1'b0; rd_req2 = 1'b0;
        chk("rr_grant_order", gbad, 0);
        chk("rr_vld_data", bad, 0);

        // done1, then done2 three cycles later, grant in release cycle
        rd_done1 = 1'b1;
        tick();
        rd_done1 = 1'b0;
        chk("done1_only_holds", buf_ready, 1);
        tick();
        tick();
        chk("done1_sticky_holds", buf_ready, 1);
        rd_done2 = 1'b1;
        rd_req1 = 1'b1; rd_addr1 = 6'd0;
        #1;
        chk("gnt_release_cycle", rd_gnt1, 1);
        tick();
        rd_done2 = 1'b0; rd_req1 = 1'b0;
        chk("release_idle", {buf_ready, busy}, 0);
        chk("frame_cnt_1", frame_cnt, 1);
        chk("vld_release_cycle", rd_vld1, 1);
        chk("data_release_cycle", rd_data1, ramp50(0, 0));

        // ---- capture 2: aborted by reset at sample 30 ----
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            ad_data = 10'(n + 500);
            tick();
        end
        chk("capture2_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_outputs", {busy, buf_ready, rd_vld1, rd_vld2, timeout}, 0);
        chk("abort_data", {rd_data1, rd_data2}, 0);
        chk("abort_frame_cnt", frame_cnt, 0);

        // ---- capture 3: fresh start from wr_ptr 0, offset ramp ----
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int n = 0; n < 3200; n++) begin
            ad_data = 10'(n + 7);
            if (busy !== 1'b1) bad++;
            tick();
        end
        chk("capture3_busy", bad, 0);
        chk("capture3_ready", buf_ready, 1);
        ready_ticks = 0;

        // tie after reset: reader 1 first
        rd_req1 = 1'b1; rd_addr1 = 6'd0;
        rd_req2 = 1'b1; rd_addr2 = 6'd63;
        #1;
        chk("post_rst_prio1", {rd_gnt1, rd_gnt2}, 2'b10);
        tick(); ready_ticks++;
        rd_req1 = 1'b0;
        chk("restart_addr0", rd_data1, ramp50(0, 7));
        tick(); ready_ticks++;
        rd_req2 = 1'b0;
        chk("restart_addr63", rd_data2, ramp50(63, 7));

`ifdef FM_SCHED_TIMEOUT_EN
        while (timeout !== 1'b1 && ready_ticks < 300) begin
            tick();
            ready_ticks++;
        end
        chk("timeout_cycle", ready_ticks, 100);
        chk("timeout_idle", buf_ready, 0);
        chk("timeout_frame_cnt", frame_cnt, 1);
        tick();
        chk("timeout_pulse_1cyc", timeout, 0);
`else
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (timeout !== 1'b0 || buf_ready !== 1'b1) bad++;
        end
        chk("no_watchdog_stays_ready", bad, 0);
        rd_done1 = 1'b1; rd_done2 = 1'b1;
        tick();
        rd_done1 = 1'b0; rd_done2 = 1'b0;
        chk("same_cycle_done_idle", buf_ready, 0);
        chk("same_cycle_done_cnt", frame_cnt, 1);
`endif

        // ---- DECIM=1 instance: one write per cycle ----
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        bad = 0;
        for (int n = 0; n < 64; n++) begin
            ad_data_b = 10'(3 * n);
            if (busy_b !== 1'b1) bad++;
            tick();
        end
        chk("d1_busy_64", bad, 0);
        chk("d1_ready", buf_ready_b, 1);
        rd_req1_b = 1'b1; rd_addr1_b = 6'd1;
        tick();
        rd_req1_b = 1'b0;
        chk("d1_addr1", rd_data1_b, 3);
        rd_req2_b = 1'b1; rd_addr2_b = 6'd63;
        tick();
        rd_req2_b = 1'b0;
        chk("d1_addr63", rd_data2_b, 189);
        rd_done1_b = 1'b1; rd_done2_b = 1'b1;
        tick();
        rd_done1_b = 1'b0; rd_done2_b = 1'b0;
        chk("d1_frame_cnt_1", frame_cnt_b, 1);

        // frames 2..256: counter wraps to zero
        bad = 0;
        for (int f = 2; f <= 256; f++) begin
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            w = 0;
            while (buf_ready_b !== 1'b1 && w < 100) begin
                tick();
                w++;
            end
            if (w != 64) bad++;
            rd_done1_b = 1'b1; rd_done2_b = 1'b1;
            tick();
            rd_done1_b = 1'b0; rd_done2_b = 1'b0;
            if (f == 255) chk("d1_frame_cnt_255", frame_cnt_b, 255);
        end
        chk("d1_frame_latency", bad, 0);
        chk("d1_frame_cnt_wrap", frame_cnt_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
